// File: rtl/pipe_mem_reader.sv
// Load unit: 256x16 data memory read through a two-stage pipeline into a
// credit-limited response FIFO, with a write-first bypass on the S2 read.
module pipe_mem_reader #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int RW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [RW-1:0] req_rd,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [RW-1:0] rsp_rd,
  output logic [AW-1:0] rsp_addr,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
    logic [RW-1:0] rd;
  } s1_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [RW-1:0] rd;
  } s2_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
    logic [AW-1:0] addr;
  } rsp_t;

  logic [DW-1:0] mem [2**AW];
  rsp_t          fifo [DEPTH];

  s1_t           s1;
  s2_t           s2;
  rsp_t          last;
  rsp_t          head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic [CW-1:0] credits;
  logic [DW-1:0] rd_data;
  logic          accept;
  logic          push;
  logic          pop;

  // Every slot in S1, S2 or the FIFO holds one credit, so S2 never stalls.
  assign credits   = CW'(count) + CW'(s1.v) + CW'(s2.v);
  assign req_ready = rst_n & (credits < CW'(DEPTH));

  assign accept    = req_valid & req_ready;
  assign push      = s2.v;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = s1.v | s2.v | rsp_valid;

  assign rd_data = (wr_en && (wr_addr == s1.addr))
                 ? wr_data : mem[s1.addr];

  // Empty FIFO shows the last popped entry rather than a stale slot.
  assign head = rsp_valid ? fifo[rptr] : last;
  assign {rsp_data, rsp_rd, rsp_addr} = head;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= '{data: s2.data, rd: s2.rd, addr: s2.addr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (accept) s1 <= '{v: 1'b1, addr: req_addr, rd: req_rd};
      else        s1.v <= 1'b0;
      s2 <= '{v: s1.v, data: rd_data, addr: s1.addr, rd: s1.rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      last  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        last <= fifo[rptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == (PW+1)'(DEPTH))));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count == '0)));

endmodule

// File: tb/tb_pipe_mem_reader.sv
// Directed bench for pipe_mem_reader: latency, throughput, credits,
// bypass, wrap and mid-flight reset.
module tb_pipe_mem_reader;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_rd;
  logic [7:0]  rsp_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int idx;
  int nreq;
  int nrsp;

  pipe_mem_reader #(
    .DW(16), .AW(8), .RW(4), .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_rd   (req_rd),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_rd   (rsp_rd),
    .rsp_addr (rsp_addr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic issue(input logic [7:0] a, input logic [3:0] r);
    req_valid = 1'b1;
    req_addr  = a;
    req_rd    = r;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_rd    = '0;
    rsp_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);

    // 1: single load, two-edge latency
    mem_write(8'h10, 16'h1234);
    rsp_ready = 1'b1;
    issue(8'h10, 4'h3);
    chk("t1_valid_n", rsp_valid, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_valid_n1", rsp_valid, 0);
    step();
    chk("t1_valid_n2", rsp_valid, 1);
    chk("t1_data", rsp_data, 16'h1234);
    chk("t1_rd", rsp_rd, 4'h3);
    chk("t1_addr", rsp_addr, 8'h10);
    step();
    chk("t1_popped", rsp_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_hold_last", rsp_data, 16'h1234);

    // 2: back-to-back loads, no bubbles
    for (int i = 0; i < 8; i++) mem_write(8'(i), 16'hA000 + 16'(i));
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_valid = 1'b1;
        req_addr  = c[7:0];
        req_rd    = c[3:0];
        chk("t2_ready", req_ready, 1);
      end else begin
        req_valid = 1'b0;
      end
      step();
      if (c >= 2) begin
        chk("t2_valid", rsp_valid, 1);
        chk("t2_data", rsp_data, 32'hA000 + c - 2);
        chk("t2_rd", rsp_rd, c - 2);
        chk("t2_addr", rsp_addr, c - 2);
      end
    end
    step();
    chk("t2_drained", rsp_valid, 0);

    // 3: backpressure, credits stop at four
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1;
      req_addr  = c[7:0];
      req_rd    = c[3:0];
      chk("t3_accept", req_ready, 1);
      step();
    end
    req_addr = 8'd4;
    req_rd   = 4'd4;
    for (int c = 0; c < 4; c++) begin
      chk("t3_full", req_ready, 0);
      step();
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_data", rsp_data, 16'hA000);
      chk("t3_hold_addr", rsp_addr, 0);
    end
    rsp_ready = 1'b1;
    idx = 4;
    for (int c = 0; c < 6; c++) begin
      req_valid = (idx < 6);
      req_addr  = 8'(idx);
      req_rd    = 4'(idx);
      chk("t3_valid", rsp_valid, 1);
      chk("t3_data", rsp_data, 32'hA000 + c);
      chk("t3_addr", rsp_addr, c);
      if (c < 3) chk("t3_credit", req_ready, (c != 0));
      if (req_valid && req_ready) idx++;
      step();
    end
    req_valid = 1'b0;
    chk("t3_empty", rsp_valid, 0);
    chk("t3_idle", busy, 0);
    chk("t3_accepted", idx, 6);

    // 4: write-first bypass on the S2 edge, none one edge later
    mem_write(8'h20, 16'h0001);
    issue(8'h20, 4'h7);
    wr_en   = 1'b1;
    wr_addr = 8'h20;
    wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    step();
    chk("t4_byp_valid", rsp_valid, 1);
    chk("t4_byp_data", rsp_data, 16'hBEEF);
    step();
    mem_write(8'h20, 16'h0001);
    rsp_ready = 1'b0;
    issue(8'h20, 4'h8);
    step();
    wr_en   = 1'b1;
    wr_addr = 8'h20;
    wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    chk("t4_late_valid", rsp_valid, 1);
    chk("t4_late_data", rsp_data, 16'h0001);
    step();
    chk("t4_late_hold", rsp_data, 16'h0001);
    chk("t4_late_rd", rsp_rd, 4'h8);
    rsp_ready = 1'b1;
    step();
    chk("t4_empty", rsp_valid, 0);

    // 5: push and pop together at count 3
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) issue(8'(c), 4'(c));
    step();
    chk("t5_full", req_ready, 0);
    chk("t5_head0", rsp_data, 16'hA000);
    rsp_ready = 1'b1;
    step();
    chk("t5_cnt3_ready", req_ready, 1);
    chk("t5_head1", rsp_data, 16'hA001);
    step();
    chk("t5_head2", rsp_data, 16'hA002);
    step();
    chk("t5_head3", rsp_data, 16'hA003);
    step();
    chk("t5_empty", rsp_valid, 0);

    // 5b: 20 loads with intermittent backpressure, pointers wrap
    nreq = 0;
    nrsp = 0;
    for (int c = 0; c < 200 && nrsp < 20; c++) begin
      rsp_ready = (c % 3 != 0);
      req_valid = (nreq < 20);
      req_addr  = 8'(nreq % 8);
      req_rd    = 4'(nreq % 16);
      if (rsp_valid && rsp_ready) begin
        chk("t5w_data", rsp_data, 32'hA000 + (nrsp % 8));
        chk("t5w_rd", rsp_rd, nrsp % 16);
        chk("t5w_addr", rsp_addr, nrsp % 8);
        nrsp++;
      end
      if (req_valid && req_ready) nreq++;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("t5w_count", nrsp, 20);
    chk("t5w_idle", busy, 0);

    // 6: reset with loads in flight and queued
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) issue(8'(c), 4'(c));
    chk("t6_busy", busy, 1);
    chk("t6_queued", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_data", rsp_data, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", req_ready, 1);
    chk("t6_rel_valid", rsp_valid, 0);
    rsp_ready = 1'b1;
    issue(8'h10, 4'h5);
    chk("t6_no_stale0", rsp_valid, 0);
    step();
    chk("t6_no_stale1", rsp_valid, 0);
    step();
    chk("t6_valid", rsp_valid, 1);
    chk("t6_data", rsp_data, 16'h1234);
    chk("t6_rd", rsp_rd, 4'h5);
    chk("t6_addr", rsp_addr, 8'h10);
    step();
    chk("t6_empty", rsp_valid, 0);
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
